hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
EX-stage issue and retire controller for DIV/DIVU, sitting directly upstream of the 32-bit multi-cycle divider.
- Latches operands and signedness, drives the divider start/annul handshake, and stalls the pipeline until the divider reports ready.
- Retires the result into the architectural HI/LO registers: HI = remainder, LO = quotient.
- Also owns the HI/LO write port used by MTHI/MTLO from WB.

Parameters:
DATA_W, 32, operand and HI/LO width; the divider is 32-bit only, so no other value is supported.
ABORT_CYCLES, 3, cycles div_start_o is held low after a flush before a new divide may issue.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ex_div_op  in  1  valid DIV/DIVU instruction in EX
ex_div_signed  in  1  1 = DIV, 0 = DIVU
ex_rs_val  in  32  dividend
ex_rt_val  in  32  divisor
flush  in  1  exception/ERET flush of EX and younger stages
wb_hi_we  in  1  MTHI write from WB
wb_lo_we  in  1  MTLO write from WB
wb_hilo_wdata  in  32  MTHI/MTLO data
div_result_i  in  64  divider result, {remainder, quotient}
div_ready_i  in  1  divider result valid
div_start_o  out  1  divider start
div_annul_o  out  1  divider cancel
div_signed_o  out  1  divider signed select
div_op1_o  out  32  divider dividend
div_op2_o  out  32  divider divisor
stall_o  out  1  hold IF/ID/EX
hi_o  out  32  architectural HI
lo_o  out  32  architectural LO

Behaviour:
- Reset (async, rst=1) clears everything:
  - state = IDLE.
  - hi_o, lo_o = 0.
  - div_start_o, div_annul_o, div_signed_o = 0; div_op1_o, div_op2_o = 0.
  - Abort counter = 0.
  - stall_o is combinational and evaluates to ex_div_op while in IDLE.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - On ex_div_op & !flush: latch rs, rt and signed into the op registers, set div_start_o = 1, go to BUSY.
  - stall_o = ex_div_op.
- BUSY:
  - div_start_o = 1; op registers and div_signed_o held constant, because the divider samples them throughout and again at sign fix-up.
  - stall_o = 1.
  - On div_ready_i & !flush: HI <= result[63:32], LO <= result[31:0]; div_start_o <= 0; go to DONE.
- DONE:
  - Exactly one cycle, with stall_o = 0 and div_start_o = 0 so the divider returns to free and the instruction leaves EX.
  - Always goes to IDLE; any new div is issued from IDLE on the following cycle.
- flush in BUSY, including the same cycle as div_ready_i:
  - Flush wins; no HI/LO write.
  - div_annul_o = 1 for one cycle, div_start_o <= 0, go to ABORT.
- flush in IDLE: no issue.
- ABORT:
  - div_start_o = 0 for ABORT_CYCLES cycles. This covers a divider sitting in its divide-by-zero path, which ignores annul and needs two cycles to reach its end state and see start low.
  - stall_o = ex_div_op; return to IDLE when the counter expires.
- Divide by zero: no special casing. The divider's returned value ({0,0}) is written to HI/LO; the result is architecturally UNPREDICTABLE.
- HI/LO write priority in the same cycle:
  - Divide retirement beats wb_hi_we/wb_lo_we, because the div is younger than the WB instruction.
  - Otherwise wb_hi_we writes HI and wb_lo_we writes LO, independently.
- hi_o and lo_o are registers. No EX-internal forwarding; MFHI/MFLO bypass is the pipeline's job.
- Latency: stall_o high from the issue cycle through the div_ready_i cycle (about 35 cycles); one DONE cycle follows.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10, ABORT=2'b11), DATA_W, HI/LO slice constants (REM_MSB=63, REM_LSB=32, QUO_MSB=31, QUO_LSB=0).
- One natural sub-module: hilo_reg, the HI/LO register pair with two prioritised write ports.
- Controller FSM and operand latches remain in hilo_div_ctrl.

Test Plan:
- DIVU 100/7 -> stall_o high until ready, then one DONE cycle; HI = 2, LO = 14; div_start_o falls the cycle after div_ready_i.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; div_signed_o and the op registers stay stable for the whole BUSY period even if ex_rs_val changes.
- Start DIV 1000/3, assert flush at BUSY cycle 10 -> one-cycle div_annul_o, no HI/LO change, three cycles of start low; a following DIVU 9/3 gives LO = 3, HI = 0.
- DIVU 5/0 followed by flush during the divide-by-zero path -> no write, no stale ready captured; the next divide gives a correct result.
- div_ready_i coincides with wb_hi_we = 1, wb_hilo_wdata = 0xDEADBEEF -> HI holds the remainder, not 0xDEADBEEF; wb_lo_we alone in IDLE sets LO = 0x12345678.
- Back-to-back DIVU 8/2 then DIVU 9/4 -> LO = 4 then 2, HI = 0 then 1; the second issues the cycle after DONE; rst asserted mid-BUSY clears hi_o, lo_o and div_start_o immediately.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU issue/retire controller and its HI/LO
// register pair: state encoding, data widths and result slice positions.
package hilo_div_ctrl_pkg;

  // The divider is 32-bit only, so this width is fixed.
  localparam int DATA_W = 32;
  localparam int RES_W  = 2 * DATA_W;

  // The divider packs its result as {remainder, quotient}.
  localparam int REM_MSB = 63;
  localparam int REM_LSB = 32;
  localparam int QUO_MSB = 31;
  localparam int QUO_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } div_state_e;

  // Remainder half of a divider result; it is retired into HI.
  function automatic logic [DATA_W-1:0] remOf(input logic [RES_W-1:0] res);
    return res[REM_MSB:REM_LSB];
  endfunction

  // Quotient half of a divider result; it is retired into LO.
  function automatic logic [DATA_W-1:0] quoOf(input logic [RES_W-1:0] res);
    return res[QUO_MSB:QUO_LSB];
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Handshake and operand bus between the EX-stage divide controller (master)
// and the multi-cycle divider (slave). Signal suffixes are from the
// controller's point of view.
interface hilo_div_ctrl_if;
  import hilo_div_ctrl_pkg::*;

  logic              div_start_o;
  logic              div_annul_o;
  logic              div_signed_o;
  logic [DATA_W-1:0] div_op1_o;
  logic [DATA_W-1:0] div_op2_o;
  logic [RES_W-1:0]  div_result_i;
  logic              div_ready_i;

  modport master (
    output div_start_o,
    output div_annul_o,
    output div_signed_o,
    output div_op1_o,
    output div_op2_o,
    input  div_result_i,
    input  div_ready_i
  );

  modport slave (
    input  div_start_o,
    input  div_annul_o,
    input  div_signed_o,
    input  div_op1_o,
    input  div_op2_o,
    output div_result_i,
    output div_ready_i
  );

endinterface

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair. A retiring divide writes both halves and
// takes priority over the WB-stage MTHI/MTLO port, because the divide is the
// younger instruction.
module hilo_reg
  import hilo_div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              div_we_i,
  input  logic [RES_W-1:0]  div_result_i,
  input  logic              wb_hi_we_i,
  input  logic              wb_lo_we_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Pick the next HI/LO values: divide retirement first, else MTHI/MTLO independently.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_we_i) begin
      hi_d = remOf(div_result_i);
      lo_d = quoOf(div_result_i);
    end else begin
      if (wb_hi_we_i) hi_d = wb_wdata_i;
      if (wb_lo_we_i) lo_d = wb_wdata_i;
    end
  end

  // Hold the architectural HI/LO values; reset clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_div_ctrl.sv
// EX-stage DIV/DIVU controller: latches operands, runs the divider start/annul
// handshake, stalls the pipeline while the divide is in flight and retires the
// result into HI (remainder) / LO (quotient).
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int unsigned ABORT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_div_op,
  input  logic              ex_div_signed,
  input  logic [DATA_W-1:0] ex_rs_val,
  input  logic [DATA_W-1:0] ex_rt_val,
  input  logic              flush,
  input  logic              wb_hi_we,
  input  logic              wb_lo_we,
  input  logic [DATA_W-1:0] wb_hilo_wdata,
  hilo_div_ctrl_if.master   div_if,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // The abort counter runs 0 .. ABORT_CYCLES-1 while start is held low.
  localparam int unsigned CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ABORT_CYCLES - 1);

  div_state_e        state_q;
  logic              start_q;
  logic              annul_q;
  logic              signed_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [CNT_W-1:0]  abort_cnt_q;

  logic              divRetire;

  // A flush in the same cycle as ready wins, so the result is dropped.
  assign divRetire = (state_q == ST_BUSY) && div_if.div_ready_i && !flush;

  // Controller FSM with registered divider handshake and operand latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      annul_q     <= 1'b0;
      signed_q    <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      abort_cnt_q <= '0;
    end else begin
      annul_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_div_op && !flush) begin
            op1_q    <= ex_rs_val;
            op2_q    <= ex_rt_val;
            signed_q <= ex_div_signed;
            start_q  <= 1'b1;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            annul_q     <= 1'b1;
            start_q     <= 1'b0;
            abort_cnt_q <= '0;
            state_q     <= ST_ABORT;
          end else if (div_if.div_ready_i) begin
            start_q <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_ABORT: begin
          if (abort_cnt_q == CNT_LAST) begin
            abort_cnt_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            abort_cnt_q <= abort_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall whenever a divide occupies EX and cannot yet leave it.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE:  stall_o = ex_div_op;
      ST_BUSY:  stall_o = 1'b1;
      ST_DONE:  stall_o = 1'b0;
      ST_ABORT: stall_o = ex_div_op;
      default:  stall_o = 1'b0;
    endcase
  end

  assign div_if.div_start_o  = start_q;
  assign div_if.div_annul_o  = annul_q;
  assign div_if.div_signed_o = signed_q;
  assign div_if.div_op1_o    = op1_q;
  assign div_if.div_op2_o    = op2_q;

  hilo_reg u_hilo_reg (
    .clk          (clk),
    .rst          (rst),
    .div_we_i     (divRetire),
    .div_result_i (div_if.div_result_i),
    .wb_hi_we_i   (wb_hi_we),
    .wb_lo_we_i   (wb_lo_we),
    .wb_wdata_i   (wb_hilo_wdata),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl. The bench plays the divider: it
// answers ready with a result computed from the operands the controller
// presents, while the expected HI/LO values are computed from the stimulus
// itself and queued at issue time.
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_op;
  logic        ex_div_signed;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        flush;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hilo_wdata;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  hilo_div_ctrl_if divBus ();

  hilo_div_ctrl #(
    .ABORT_CYCLES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_div_op     (ex_div_op),
    .ex_div_signed (ex_div_signed),
    .ex_rs_val     (ex_rs_val),
    .ex_rt_val     (ex_rt_val),
    .flush         (flush),
    .wb_hi_we      (wb_hi_we),
    .wb_lo_we      (wb_lo_we),
    .wb_hilo_wdata (wb_hilo_wdata),
    .div_if        (divBus),
    .stall_o       (stall_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sbQueue[$];
  logic [31:0] hiExp;
  logic [31:0] loExp;
  logic [31:0] curA;
  logic [31:0] curB;
  logic        curS;

  // Reference divide with truncation toward zero; divide by zero returns {0,0}.
  function automatic logic [63:0] divModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a divide in IDLE, push its expected result, step into BUSY.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    ex_div_op     = 1'b1;
    ex_div_signed = sgn;
    ex_rs_val     = a;
    ex_rt_val     = b;
    curA = a;
    curB = b;
    curS = sgn;
    sbQueue.push_back(divModel(sgn, a, b));
    #1 checkOutput("issueStall", 64'(stall_o), 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("busyStart", 64'(divBus.div_start_o), 64'd1);
    checkOutput("busySigned", 64'(divBus.div_signed_o), 64'(curS));
    checkOutput("busyOp1", 64'(divBus.div_op1_o), 64'(curA));
    checkOutput("busyOp2", 64'(divBus.div_op2_o), 64'(curB));
  endtask

  // Run n BUSY cycles, optionally scrambling the dividend input.
  task automatic busyCycles(input int n, input bit wiggle);
    for (int i = 0; i < n; i++) begin
      if (wiggle) ex_rs_val = $urandom;
      #1;
      checkOutput("busyStall", 64'(stall_o), 64'd1);
      checkOutput("busyStartHeld", 64'(divBus.div_start_o), 64'd1);
      checkOutput("busyAnnul", 64'(divBus.div_annul_o), 64'd0);
      checkOutput("busyOp1Held", 64'(divBus.div_op1_o), 64'(curA));
      checkOutput("busyOp2Held", 64'(divBus.div_op2_o), 64'(curB));
      checkOutput("busySignedHeld", 64'(divBus.div_signed_o), 64'(curS));
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Divider reports ready; check DONE then IDLE, optionally with a WB write.
  task automatic retire(input bit wbHi, input bit wbLo, input logic [31:0] wdata);
    logic [63:0] exp;
    divBus.div_ready_i  = 1'b1;
    divBus.div_result_i = divModel(divBus.div_signed_o, divBus.div_op1_o, divBus.div_op2_o);
    wb_hi_we      = wbHi;
    wb_lo_we      = wbLo;
    wb_hilo_wdata = wdata;
    #1;
    checkOutput("readyStall", 64'(stall_o), 64'd1);
    checkOutput("readyStart", 64'(divBus.div_start_o), 64'd1);
    @(posedge clk); @(negedge clk);
    divBus.div_ready_i  = 1'b0;
    divBus.div_result_i = '0;
    wb_hi_we = 1'b0;
    wb_lo_we = 1'b0;
    exp   = sbQueue.pop_front();
    hiExp = exp[63:32];
    loExp = exp[31:0];
    checkOutput("doneStall", 64'(stall_o), 64'd0);
    checkOutput("doneStart", 64'(divBus.div_start_o), 64'd0);
    checkOutput("doneHi", 64'(hi_o), 64'(hiExp));
    checkOutput("doneLo", 64'(lo_o), 64'(loExp));
    ex_div_op = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("idleStall", 64'(stall_o), 64'd0);
    checkOutput("idleStart", 64'(divBus.div_start_o), 64'd0);
  endtask

  // Flush in BUSY (optionally alongside ready), then walk ABORT and preload the next divide.
  task automatic flushAbort(input bit withReady, input bit staleReady,
                            input logic [31:0] nextA, input logic [31:0] nextB);
    flush = 1'b1;
    if (withReady) begin
      divBus.div_ready_i  = 1'b1;
      divBus.div_result_i = 64'hAAAA_5555_1234_5678;
    end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    divBus.div_ready_i  = 1'b0;
    divBus.div_result_i = '0;
    ex_div_op = 1'b0;
    void'(sbQueue.pop_back());
    #1;
    checkOutput("abortAnnul", 64'(divBus.div_annul_o), 64'd1);
    checkOutput("abortStart1", 64'(divBus.div_start_o), 64'd0);
    checkOutput("abortStall", 64'(stall_o), 64'd0);
    checkOutput("abortHi", 64'(hi_o), 64'(hiExp));
    checkOutput("abortLo", 64'(lo_o), 64'(loExp));
    if (staleReady) begin
      divBus.div_ready_i  = 1'b1;
      divBus.div_result_i = 64'h0BAD_0BAD_0BAD_0BAD;
    end
    @(posedge clk); @(negedge clk);
    divBus.div_ready_i  = 1'b0;
    divBus.div_result_i = '0;
    checkOutput("abortAnnulOne", 64'(divBus.div_annul_o), 64'd0);
    checkOutput("abortStart2", 64'(divBus.div_start_o), 64'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("abortStart3", 64'(divBus.div_start_o), 64'd0);
    checkOutput("staleHi", 64'(hi_o), 64'(hiExp));
    checkOutput("staleLo", 64'(lo_o), 64'(loExp));
    ex_div_op     = 1'b1;
    ex_div_signed = 1'b0;
    ex_rs_val     = nextA;
    ex_rt_val     = nextB;
    #1 checkOutput("abortStallOp", 64'(stall_o), 64'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("postAbortStart", 64'(divBus.div_start_o), 64'd0);
    checkOutput("postAbortStall", 64'(stall_o), 64'd1);
  endtask

  // MTHI/MTLO write from WB while the controller is idle.
  task automatic wbWrite(input bit hiWe, input bit loWe, input logic [31:0] data);
    wb_hi_we      = hiWe;
    wb_lo_we      = loWe;
    wb_hilo_wdata = data;
    @(posedge clk); @(negedge clk);
    wb_hi_we = 1'b0;
    wb_lo_we = 1'b0;
    if (hiWe) hiExp = data;
    if (loWe) loExp = data;
    checkOutput("wbHi", 64'(hi_o), 64'(hiExp));
    checkOutput("wbLo", 64'(lo_o), 64'(loExp));
  endtask

  // Runaway guard in case the sequence ever stops advancing.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    rst                 = 1'b1;
    ex_div_op           = 1'b0;
    ex_div_signed       = 1'b0;
    ex_rs_val           = '0;
    ex_rt_val           = '0;
    flush               = 1'b0;
    wb_hi_we            = 1'b0;
    wb_lo_we            = 1'b0;
    wb_hilo_wdata       = '0;
    divBus.div_ready_i  = 1'b0;
    divBus.div_result_i = '0;
    hiExp = '0;
    loExp = '0;

    @(negedge clk);
    checkOutput("rstHi", 64'(hi_o), 64'd0);
    checkOutput("rstLo", 64'(lo_o), 64'd0);
    checkOutput("rstStart", 64'(divBus.div_start_o), 64'd0);
    checkOutput("rstAnnul", 64'(divBus.div_annul_o), 64'd0);
    checkOutput("rstSigned", 64'(divBus.div_signed_o), 64'd0);
    checkOutput("rstOp1", 64'(divBus.div_op1_o), 64'd0);
    checkOutput("rstOp2", 64'(divBus.div_op2_o), 64'd0);
    checkOutput("rstStallIdle", 64'(stall_o), 64'd0);
    ex_div_op = 1'b1;
    #1 checkOutput("rstStallOp", 64'(stall_o), 64'd1);
    ex_div_op = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("[TB] DIVU 100/7");
    applyStimulus(1'b0, 32'd100, 32'd7);
    busyCycles(33, 1'b0);
    retire(1'b0, 1'b0, 32'd0);
    checkOutput("divu100by7Hi", 64'(hi_o), 64'd2);
    checkOutput("divu100by7Lo", 64'(lo_o), 64'd14);

    $display("[TB] DIV -7/2 with dividend input changing during BUSY");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    busyCycles(20, 1'b1);
    retire(1'b0, 1'b0, 32'd0);
    checkOutput("divNeg7by2Lo", 64'(lo_o), 64'hFFFF_FFFD);

    $display("[TB] MTLO / MTHI in IDLE");
    wbWrite(1'b0, 1'b1, 32'h1234_5678);
    wbWrite(1'b1, 1'b0, 32'hCAFE_F00D);

    $display("[TB] DIV 1000/3 flushed at BUSY cycle 10, then DIVU 9/3");
    applyStimulus(1'b1, 32'd1000, 32'd3);
    busyCycles(9, 1'b0);
    flushAbort(1'b0, 1'b0, 32'd9, 32'd3);
    applyStimulus(1'b0, 32'd9, 32'd3);
    busyCycles(30, 1'b0);
    retire(1'b0, 1'b0, 32'd0);

    $display("[TB] DIVU 5/0 flushed with ready, stale ready in ABORT");
    applyStimulus(1'b0, 32'd5, 32'd0);
    busyCycles(2, 1'b0);
    flushAbort(1'b1, 1'b1, 32'd8, 32'd2);

    $display("[TB] back-to-back DIVU 8/2, DIVU 9/4 with MTHI on retire");
    applyStimulus(1'b0, 32'd8, 32'd2);
    busyCycles(31, 1'b0);
    retire(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd9, 32'd4);
    busyCycles(31, 1'b0);
    retire(1'b1, 1'b0, 32'hDEAD_BEEF);
    checkOutput("retireBeatsWbHi", 64'(hi_o), 64'd1);

    $display("[TB] reset mid-BUSY");
    applyStimulus(1'b0, 32'd7, 32'd1);
    busyCycles(3, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midRstHi", 64'(hi_o), 64'd0);
    checkOutput("midRstLo", 64'(lo_o), 64'd0);
    checkOutput("midRstStart", 64'(divBus.div_start_o), 64'd0);
    void'(sbQueue.pop_back());
    hiExp = '0;
    loExp = '0;
    ex_div_op = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("postRstStall", 64'(stall_o), 64'd0);
    checkOutput("postRstStart", 64'(divBus.div_start_o), 64'd0);
    checkOutput("sbEmpty", 64'(sbQueue.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
